f_fetch_unit: RTL and testbench



---
 rtl/f_fetch_unit_if.sv | 23 ++
 rtl/f_fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_f_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_fetch_unit_if.sv
// Instruction memory request/response bus between fetch and imem.
// Latency: combinational; the response is valid in the same cycle as ack.
// Backpressure: the requester holds req/addr stable until ack.
interface f_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/f_fetch_unit.sv
// F-stage fetch: owns the fetch PC, drives imem, presents instr/pc/slot/exc to IF/ID.
// Latency: zero-wait memory gives 1 instr/cycle; each imem wait cycle adds one.
// Backpressure: D_stall parks an acked word in HOLD; imem req/addr stay stable until ack.
module f_fetch_unit (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req,
    input  logic                  D_is_eret,
    input  logic [31:0]           EPC,
    input  logic                  D_is_jump,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    input  logic                  D_stall,
    f_fetch_unit_if.master        imem,
    output logic                  F_valid,
    output logic [31:0]           F_Instr,
    output logic [31:0]           F_pc,
    output logic                  F_Delaycheck,
    output logic [4:0]            F_ExcCode
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] RANGE_LO = 32'h0000_3000;
    localparam logic [31:0] RANGE_HI = 32'h0000_6ffc;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] tgt, tgt_nxt;
    logic        slot_pending, slot_pending_nxt;
    logic        tgt_pending, tgt_pending_nxt;

    logic        bad;
    logic        eret_go;
    logic        branch_go;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        raw_valid;
    logic        handoff;
    logic [31:0] next_pc;

    assign bad         = (pc[1:0] != 2'b00) || (pc < RANGE_LO) || (pc > RANGE_HI);
    assign eret_go     = D_is_eret & ~D_stall;
    assign branch_go   = D_is_jump & ~D_stall;
    assign redirect    = Req | eret_go;
    assign redirect_pc = Req ? EXC_PC : EPC;

    // Output decode: what F presents this cycle and what it asks of imem.
    always_comb begin
        raw_valid      = 1'b0;
        F_Instr        = 32'h0;
        F_ExcCode      = 5'd0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        case (state)
            ST_REQ: begin
                if (bad) begin
                    // Faulting fetch never touches memory; it flows down as a bubble carrying AdEL.
                    raw_valid = 1'b1;
                    F_ExcCode = EXC_ADEL;
                end else begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_ack) begin
                        raw_valid = 1'b1;
                        F_Instr   = imem.imem_rdata;
                    end
                end
            end
            ST_HOLD: begin
                raw_valid = 1'b1;
                F_Instr   = buf_instr;
            end
            ST_DRAIN: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = drain_addr;
            end
            default: ;
        endcase
        // A redirect squashes whatever F holds this cycle (eret has no delay slot).
        F_valid      = raw_valid & ~redirect;
        handoff      = F_valid & ~D_stall;
        F_pc         = pc;
        F_Delaycheck = D_is_jump | slot_pending;
    end

    // Sequential successor: a branch resolving with its slot handed off wins, then a deferred target.
    always_comb begin
        if (D_is_jump & br_taken)
            next_pc = br_target;
        else if (tgt_pending)
            next_pc = tgt;
        else
            next_pc = pc + 32'd4;
    end

    // Next-state: FSM transitions, PC update, delay-slot bookkeeping and word buffering.
    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        drain_addr_nxt   = drain_addr;
        buf_instr_nxt    = buf_instr;
        tgt_nxt          = tgt;
        slot_pending_nxt = slot_pending;
        tgt_pending_nxt  = tgt_pending;

        case (state)
            ST_REQ: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                    // Only a request actually on the bus and not yet acked must be drained.
                    if (imem.imem_req && !imem.imem_ack) begin
                        drain_addr_nxt = pc;
                        state_nxt      = ST_DRAIN;
                    end
                end else if (handoff) begin
                    pc_nxt = next_pc;
                end else if (imem.imem_req && imem.imem_ack) begin
                    buf_instr_nxt = imem.imem_rdata;
                    state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_REQ;
                end else if (handoff) begin
                    pc_nxt    = next_pc;
                    state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect)
                    pc_nxt = redirect_pc;
                if (imem.imem_ack)
                    state_nxt = ST_REQ;
            end
            default: state_nxt = ST_REQ;
        endcase

        if (Req) begin
            slot_pending_nxt = 1'b0;
            tgt_pending_nxt  = 1'b0;
        end else if (handoff) begin
            slot_pending_nxt = 1'b0;
            tgt_pending_nxt  = 1'b0;
        end else if (branch_go) begin
            // Branch left D before its slot was fetched: remember slot and target.
            slot_pending_nxt = 1'b1;
            tgt_pending_nxt  = br_taken;
            tgt_nxt          = br_target;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_REQ;
            pc           <= RESET_PC;
            drain_addr   <= 32'h0;
            buf_instr    <= 32'h0;
            tgt          <= 32'h0;
            slot_pending <= 1'b0;
            tgt_pending  <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            drain_addr   <= drain_addr_nxt;
            buf_instr    <= buf_instr_nxt;
            tgt          <= tgt_nxt;
            slot_pending <= slot_pending_nxt;
            tgt_pending  <= tgt_pending_nxt;
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit with a combinational imem model.
// Latency: inputs applied 1ns after posedge, outputs sampled 2ns later.
// Backpressure: ack and D_stall are scripted per cycle.
module tb_f_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        D_is_eret;
    logic [31:0] EPC;
    logic        D_is_jump;
    logic        br_taken;
    logic [31:0] br_target;
    logic        D_stall;
    logic        F_valid;
    logic [31:0] F_Instr;
    logic [31:0] F_pc;
    logic        F_Delaycheck;
    logic [4:0]  F_ExcCode;

    int n_checks;
    int n_errors;

    f_fetch_unit_if imem ();

    // Memory word is a fixed function of the address.
    assign imem.imem_rdata = imem.imem_addr ^ 32'hA5A5_0000;

    f_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .Req          (Req),
        .D_is_eret    (D_is_eret),
        .EPC          (EPC),
        .D_is_jump    (D_is_jump),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .D_stall      (D_stall),
        .imem         (imem.master),
        .F_valid      (F_valid),
        .F_Instr      (F_Instr),
        .F_pc         (F_pc),
        .F_Delaycheck (F_Delaycheck),
        .F_ExcCode    (F_ExcCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        Req           = 1'b0;
        D_is_eret     = 1'b0;
        EPC           = 32'h0;
        D_is_jump     = 1'b0;
        br_taken      = 1'b0;
        br_target     = 32'h0;
        D_stall       = 1'b0;
        imem.imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle_inputs();

        // Reset state and zero-wait streaming.
        do_reset();
        settle();
        check("rst_req",   {31'h0, imem.imem_req}, 32'h1);
        check("rst_addr",  imem.imem_addr, 32'h0000_3000);
        check("rst_valid", {31'h0, F_valid}, 32'h0);
        imem.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h0000_3000 + 32'(i * 4);
            settle();
            check("seq_valid", {31'h0, F_valid}, 32'h1);
            check("seq_pc",    F_pc, exp_pc);
            check("seq_instr", F_Instr, exp_pc ^ 32'hA5A5_0000);
            check("seq_dly",   {31'h0, F_Delaycheck}, 32'h0);
            check("seq_exc",   {27'h0, F_ExcCode}, 32'h0);
            tick();
        end

        // Ack delayed 3 cycles under a 5-cycle D stall: word parked in HOLD.
        do_reset();
        D_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("wait_valid", {31'h0, F_valid}, 32'h0);
            check("wait_addr",  imem.imem_addr, 32'h0000_3000);
            tick();
        end
        imem.imem_ack = 1'b1;
        settle();
        check("ack_valid", {31'h0, F_valid}, 32'h1);
        check("ack_instr", F_Instr, 32'hA5A5_3000);
        tick();
        imem.imem_ack = 1'b0;
        settle();
        check("hold_req",   {31'h0, imem.imem_req}, 32'h0);
        check("hold_valid", {31'h0, F_valid}, 32'h1);
        check("hold_instr", F_Instr, 32'hA5A5_3000);
        check("hold_pc",    F_pc, 32'h0000_3000);
        tick();
        D_stall = 1'b0;
        settle();
        check("rel_valid", {31'h0, F_valid}, 32'h1);
        check("rel_pc",    F_pc, 32'h0000_3000);
        tick();
        settle();
        check("next_req",  {31'h0, imem.imem_req}, 32'h1);
        check("next_addr", imem.imem_addr, 32'h0000_3004);

        // Taken branch in D while its slot (0x3008) is handed off.
        do_reset();
        imem.imem_ack = 1'b1;
        tick();
        tick();
        D_is_jump = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h0000_3100;
        settle();
        check("br_slot_pc",  F_pc, 32'h0000_3008);
        check("br_slot_dly", {31'h0, F_Delaycheck}, 32'h1);
        tick();
        D_is_jump = 1'b0;
        br_taken  = 1'b0;
        settle();
        check("br_tgt_pc",  F_pc, 32'h0000_3100);
        check("br_tgt_dly", {31'h0, F_Delaycheck}, 32'h0);

        // Same branch leaves D while F waits on ack: slot and target deferred.
        do_reset();
        imem.imem_ack = 1'b1;
        tick();
        tick();
        imem.imem_ack = 1'b0;
        D_is_jump = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h0000_3100;
        settle();
        check("dbr_wait_valid", {31'h0, F_valid}, 32'h0);
        tick();
        D_is_jump = 1'b0;
        br_taken  = 1'b0;
        imem.imem_ack = 1'b1;
        settle();
        check("dbr_slot_pc",  F_pc, 32'h0000_3008);
        check("dbr_slot_dly", {31'h0, F_Delaycheck}, 32'h1);
        tick();
        settle();
        check("dbr_tgt_pc",  F_pc, 32'h0000_3100);
        check("dbr_tgt_dly", {31'h0, F_Delaycheck}, 32'h0);

        // Req while a request is outstanding, with a deferred branch pending.
        do_reset();
        D_is_jump = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h0000_3100;
        tick();
        D_is_jump = 1'b0;
        br_taken  = 1'b0;
        Req       = 1'b1;
        settle();
        check("req_valid", {31'h0, F_valid}, 32'h0);
        tick();
        Req = 1'b0;
        settle();
        check("drain_valid", {31'h0, F_valid}, 32'h0);
        check("drain_addr",  imem.imem_addr, 32'h0000_3000);
        check("drain_req",   {31'h0, imem.imem_req}, 32'h1);
        tick();
        imem.imem_ack = 1'b1;
        settle();
        check("drain_ack_valid", {31'h0, F_valid}, 32'h0);
        tick();
        imem.imem_ack = 1'b0;
        settle();
        check("exc_addr", imem.imem_addr, 32'h0000_4180);
        check("exc_dly",  {31'h0, F_Delaycheck}, 32'h0);
        tick();
        imem.imem_ack = 1'b1;
        settle();
        check("exc_pc",    F_pc, 32'h0000_4180);
        check("exc_valid", {31'h0, F_valid}, 32'h1);
        tick();
        settle();
        check("exc_next_pc", F_pc, 32'h0000_4184);

        // eret to a misaligned EPC, then a walk past the top of the legal range.
        do_reset();
        imem.imem_ack = 1'b1;
        D_is_eret     = 1'b1;
        EPC           = 32'h0000_3002;
        settle();
        check("eret_valid", {31'h0, F_valid}, 32'h0);
        tick();
        D_is_eret     = 1'b0;
        imem.imem_ack = 1'b0;
        settle();
        check("mis_req",   {31'h0, imem.imem_req}, 32'h0);
        check("mis_valid", {31'h0, F_valid}, 32'h1);
        check("mis_pc",    F_pc, 32'h0000_3002);
        check("mis_instr", F_Instr, 32'h0);
        check("mis_exc",   {27'h0, F_ExcCode}, 32'h4);
        tick();
        D_is_eret = 1'b1;
        EPC       = 32'h0000_6ff8;
        settle();
        check("mis2_pc", F_pc, 32'h0000_3006);
        tick();
        D_is_eret     = 1'b0;
        imem.imem_ack = 1'b1;
        settle();
        check("top_pc0",  F_pc, 32'h0000_6ff8);
        check("top_exc0", {27'h0, F_ExcCode}, 32'h0);
        tick();
        settle();
        check("top_pc1",  F_pc, 32'h0000_6ffc);
        check("top_exc1", {27'h0, F_ExcCode}, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("oor_pc",    F_pc, 32'h0000_7000 + 32'(i * 4));
            check("oor_req",   {31'h0, imem.imem_req}, 32'h0);
            check("oor_instr", F_Instr, 32'h0);
            check("oor_exc",   {27'h0, F_ExcCode}, 32'h4);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Bound the run in case the scripted sequence is ever stalled.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
